cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between the two result producers, ALU and memory/load-store unit. It buffers each producer's results in a small FIFO, grants the bus round-robin, and broadcasts one `{value, rob id}` per cycle. The RS, ROB and LSB wakeup logic all consume this broadcast. Flush empties all buffered results.

---
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU/MEM results and broadcasts one {value, rob id} per cycle, round-robin.
// Latency: 2 edges input-to-broadcast; 1 edge when `CDB_BYPASS_EN` lets an empty FIFO be bypassed.
// Backpressure: MEM via mem_ready_out; ALU has none, so alu_stall_out throttles issue and overflow is sticky.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

// cdb_fifo: circular buffer with head visible combinationally, synchronous flush.
// Latency: push at edge E is the head after E.
// Backpressure: pushes while full are dropped; caller must only pop when count > 0.
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push_ok;

    assign push_ok  = push && (count != CW'(DEPTH));
    assign head_dat = mem[head];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok && !flush) mem[tail] <= push_dat;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      need_flush_in,
    input  logic                      alu_valid_in,
    input  logic [31:0]               alu_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_dependency_in,
    output logic                      alu_stall_out,
    input  logic                      mem_valid_in,
    input  logic [31:0]               mem_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0] mem_dependency_in,
    output logic                      mem_ready_out,
    output logic                      cdb_valid_out,
    output logic [31:0]               cdb_value_out,
    output logic [ROB_SIZE_WIDTH-1:0] cdb_dependency_out,
    output logic                      cdb_src_out,
    output logic                      alu_overflow_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]               value;
        logic [ROB_SIZE_WIDTH-1:0] dep;
    } cdb_ent_t;

    cdb_ent_t      alu_in_dat, mem_in_dat, alu_head_dat, mem_head_dat, grant_dat;
    logic [CW-1:0] alu_count, mem_count;
    logic          go, flush;
    logic          alu_head_vld, mem_head_vld;
    logic          alu_byp, mem_byp;
    logic          alu_cand, mem_cand;
    logic          gnt_alu, gnt_mem;
    logic          alu_push, mem_push, alu_pop, mem_pop, alu_ovf;
    logic          last_grant;

    assign alu_in_dat    = '{value: alu_value_in, dep: alu_dependency_in};
    assign mem_in_dat    = '{value: mem_value_in, dep: mem_dependency_in};
    assign go            = rdy_in && !need_flush_in;
    assign flush         = rdy_in && need_flush_in;
    assign alu_head_vld  = (alu_count != '0);
    assign mem_head_vld  = (mem_count != '0);
    assign alu_stall_out = (alu_count >= CW'(FIFO_DEPTH - 1));
    assign mem_ready_out = (mem_count < CW'(FIFO_DEPTH));

`ifdef CDB_BYPASS_EN
    // An empty FIFO lets its live input stand in as the candidate.
    assign alu_byp = !alu_head_vld && alu_valid_in;
    assign mem_byp = !mem_head_vld && mem_valid_in && mem_ready_out;
`else
    assign alu_byp = 1'b0;
    assign mem_byp = 1'b0;
`endif

    assign alu_cand = alu_head_vld || alu_byp;
    assign mem_cand = mem_head_vld || mem_byp;

    // On contention the source not granted last time wins.
    assign gnt_mem = go && mem_cand && (!alu_cand || !last_grant);
    assign gnt_alu = go && alu_cand && !gnt_mem;

    assign alu_pop  = gnt_alu && alu_head_vld;
    assign mem_pop  = gnt_mem && mem_head_vld;
    assign alu_push = go && alu_valid_in && !(gnt_alu && alu_byp);
    assign mem_push = go && mem_valid_in && mem_ready_out && !(gnt_mem && mem_byp);
    assign alu_ovf  = go && alu_valid_in && (alu_count == CW'(FIFO_DEPTH));

    always_comb begin
        grant_dat = alu_head_vld ? alu_head_dat : alu_in_dat;
        if (gnt_mem) grant_dat = mem_head_vld ? mem_head_dat : mem_in_dat;
    end

    cdb_fifo #(.W($bits(cdb_ent_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (flush),
        .push     (alu_push),
        .push_dat (alu_in_dat),
        .pop      (alu_pop),
        .head_dat (alu_head_dat),
        .count    (alu_count)
    );

    cdb_fifo #(.W($bits(cdb_ent_t)), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (flush),
        .push     (mem_push),
        .push_dat (mem_in_dat),
        .pop      (mem_pop),
        .head_dat (mem_head_dat),
        .count    (mem_count)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_out      <= 1'b0;
            cdb_value_out      <= '0;
            cdb_dependency_out <= '0;
            cdb_src_out        <= 1'b0;
            alu_overflow_out   <= 1'b0;
            last_grant         <= 1'b0;
        end else if (rdy_in) begin
            if (need_flush_in) begin
                cdb_valid_out <= 1'b0;
            end else begin
                cdb_valid_out <= gnt_alu || gnt_mem;
                if (gnt_alu || gnt_mem) begin
                    cdb_value_out      <= grant_dat.value;
                    cdb_dependency_out <= grant_dat.dep;
                    cdb_src_out        <= gnt_mem;
                    last_grant         <= gnt_mem;
                end
                if (alu_ovf) alu_overflow_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, backpressure, flush, overflow, async reset.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        need_flush_in = 1'b0;
    logic        alu_valid_in = 1'b0;
    logic [31:0] alu_value_in = '0;
    logic [3:0]  alu_dependency_in = '0;
    logic        alu_stall_out;
    logic        mem_valid_in = 1'b0;
    logic [31:0] mem_value_in = '0;
    logic [3:0]  mem_dependency_in = '0;
    logic        mem_ready_out;
    logic        cdb_valid_out;
    logic [31:0] cdb_value_out;
    logic [3:0]  cdb_dependency_out;
    logic        cdb_src_out;
    logic        alu_overflow_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.ROB_SIZE_WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .need_flush_in      (need_flush_in),
        .alu_valid_in       (alu_valid_in),
        .alu_value_in       (alu_value_in),
        .alu_dependency_in  (alu_dependency_in),
        .alu_stall_out      (alu_stall_out),
        .mem_valid_in       (mem_valid_in),
        .mem_value_in       (mem_value_in),
        .mem_dependency_in  (mem_dependency_in),
        .mem_ready_out      (mem_ready_out),
        .cdb_valid_out      (cdb_valid_out),
        .cdb_value_out      (cdb_value_out),
        .cdb_dependency_out (cdb_dependency_out),
        .cdb_src_out        (cdb_src_out),
        .alu_overflow_out   (alu_overflow_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_in  = 1'b0;
        mem_valid_in  = 1'b0;
        need_flush_in = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_in = 1'b0;
        #1;
        checks++;
        if ({cdb_valid_out, cdb_src_out, alu_overflow_out, cdb_dependency_out, cdb_value_out} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b s=%0b o=%0b d=%0d val=%h want all 0",
                     cdb_valid_out, cdb_src_out, alu_overflow_out, cdb_dependency_out, cdb_value_out);
        end
        checks++;
        if (mem_ready_out !== 1'b1 || alu_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flow: got ready=%0b stall=%0b want ready=1 stall=0", mem_ready_out, alu_stall_out);
        end
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        checks++;
        if (cdb_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %0b want 0", cdb_valid_out);
        end
    endtask

    task automatic test_single_alu();
        alu_valid_in      = 1'b1;
        alu_value_in      = 32'h0000_1234;
        alu_dependency_in = 4'd3;
        tick();
        alu_valid_in = 1'b0;
`ifndef CDB_BYPASS_EN
        checks++;
        if (cdb_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%0b want 0 one edge after capture", cdb_valid_out);
        end
        tick();
`endif
        checks++;
        if (cdb_valid_out !== 1'b1 || cdb_value_out !== 32'h0000_1234 || cdb_dependency_out !== 4'd3 || cdb_src_out !== 1'b0) begin
            errors++;
            $display("FAIL single_bcast: got v=%0b val=%h d=%0d s=%0b want v=1 val=00001234 d=3 s=0",
                     cdb_valid_out, cdb_value_out, cdb_dependency_out, cdb_src_out);
        end
        tick();
        checks++;
        if (cdb_valid_out !== 1'b0 || cdb_value_out !== 32'h0000_1234) begin
            errors++;
            $display("FAIL single_after: got v=%0b val=%h want v=0 val held 00001234", cdb_valid_out, cdb_value_out);
        end
    endtask

    task automatic test_contention();
        logic [3:0]  exp_dep [4] = '{4'd5, 4'd1, 4'd6, 4'd2};
        logic        exp_src [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_val [4] = '{32'h55, 32'h11, 32'h66, 32'h22};
        force dut.alu_cand = 1'b0;
        force dut.mem_cand = 1'b0;
        alu_valid_in = 1'b1; alu_value_in = 32'h11; alu_dependency_in = 4'd1;
        mem_valid_in = 1'b1; mem_value_in = 32'h55; mem_dependency_in = 4'd5;
        tick();
        alu_value_in = 32'h22; alu_dependency_in = 4'd2;
        mem_value_in = 32'h66; mem_dependency_in = 4'd6;
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid_out !== 1'b0 || dut.alu_count !== 3'd2 || dut.mem_count !== 3'd2) begin
            errors++;
            $display("FAIL cont_fill: got v=%0b alu_cnt=%0d mem_cnt=%0d want v=0 2 2",
                     cdb_valid_out, dut.alu_count, dut.mem_count);
        end
        release dut.alu_cand;
        release dut.mem_cand;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cdb_valid_out !== 1'b1 || cdb_dependency_out !== exp_dep[i] || cdb_src_out !== exp_src[i] || cdb_value_out !== exp_val[i]) begin
                errors++;
                $display("FAIL cont_order[%0d]: got v=%0b d=%0d s=%0b val=%h want v=1 d=%0d s=%0b val=%h",
                         i, cdb_valid_out, cdb_dependency_out, cdb_src_out, cdb_value_out, exp_dep[i], exp_src[i], exp_val[i]);
            end
        end
        tick();
        checks++;
        if (cdb_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL cont_drained: got v=%0b want 0", cdb_valid_out);
        end
    endtask

    task automatic test_backpressure();
        force dut.alu_cand = 1'b0;
        force dut.mem_cand = 1'b0;
        alu_valid_in = 1'b1;
        mem_valid_in = 1'b1;
        checks++;
        if (mem_ready_out !== 1'b1 || alu_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_cnt0: got ready=%0b stall=%0b want 1 0", mem_ready_out, alu_stall_out);
        end
        for (int i = 1; i <= 4; i++) begin
            alu_dependency_in = 4'(i - 1); alu_value_in = 32'(i);
            mem_dependency_in = 4'(i + 7); mem_value_in = 32'(i + 100);
            tick();
            checks++;
            if (mem_ready_out !== (i < 4) || alu_stall_out !== (i >= 3)) begin
                errors++;
                $display("FAIL bp_cnt%0d: got ready=%0b stall=%0b want ready=%0b stall=%0b",
                         i, mem_ready_out, alu_stall_out, (i < 4), (i >= 3));
            end
        end
        alu_valid_in = 1'b0;
        mem_dependency_in = 4'd12;
        tick();
        checks++;
        if (dut.mem_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_no_xfer: got mem_cnt=%0d want 4", dut.mem_count);
        end
        mem_valid_in = 1'b0;
        release dut.alu_cand;
        release dut.mem_cand;
        tick();
        checks++;
        if (cdb_valid_out !== 1'b1 || cdb_dependency_out !== 4'd8 || cdb_src_out !== 1'b1 || mem_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: got v=%0b d=%0d s=%0b ready=%0b want 1 8 1 1",
                     cdb_valid_out, cdb_dependency_out, cdb_src_out, mem_ready_out);
        end
        need_flush_in = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        force dut.alu_cand = 1'b0;
        alu_valid_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_dependency_in = 4'(i); alu_value_in = 32'(i + 32'h300);
            tick();
        end
        alu_valid_in = 1'b0;
        checks++;
        if (alu_stall_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_stall: got %0b want 1 with 3 buffered", alu_stall_out);
        end
        release dut.alu_cand;
        need_flush_in = 1'b1;
        alu_valid_in = 1'b1; alu_dependency_in = 4'd7; alu_value_in = 32'h777;
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid_out !== 1'b0 || dut.alu_count !== 3'd0 || dut.mem_count !== 3'd0 || alu_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got v=%0b alu_cnt=%0d mem_cnt=%0d stall=%0b want 0 0 0 0",
                     cdb_valid_out, dut.alu_count, dut.mem_count, alu_stall_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cdb_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_bcast[%0d]: got v=%0b d=%0d want v=0", i, cdb_valid_out, cdb_dependency_out);
            end
        end
    endtask

    task automatic test_overflow();
        force dut.alu_cand = 1'b0;
        alu_valid_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            alu_dependency_in = 4'(i); alu_value_in = 32'(i + 32'hA0);
            tick();
            if (i == 4) begin
                checks++;
                if (alu_overflow_out !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: got %0b want 0 at 4 entries", alu_overflow_out);
                end
            end
        end
        alu_valid_in = 1'b0;
        checks++;
        if (alu_overflow_out !== 1'b1 || dut.alu_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%0b cnt=%0d want 1 4", alu_overflow_out, dut.alu_count);
        end
        release dut.alu_cand;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (cdb_valid_out !== 1'b1 || cdb_dependency_out !== 4'(i) || cdb_value_out !== 32'(i + 32'hA0)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got v=%0b d=%0d val=%h want v=1 d=%0d val=%h",
                         i, cdb_valid_out, cdb_dependency_out, cdb_value_out, i, i + 32'hA0);
            end
        end
        tick();
        checks++;
        if (cdb_valid_out !== 1'b0 || alu_overflow_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fifth_dropped: got v=%0b d=%0d ovf=%0b want v=0 ovf=1",
                     cdb_valid_out, cdb_dependency_out, alu_overflow_out);
        end
    endtask

    task automatic test_async_reset();
        alu_valid_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_dependency_in = 4'(i); alu_value_in = 32'(i + 32'hB0);
            tick();
        end
        checks++;
        if (cdb_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL arst_stream: got v=%0b want 1 before reset", cdb_valid_out);
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({cdb_valid_out, cdb_src_out, alu_overflow_out, cdb_dependency_out, cdb_value_out} !== 39'd0 ||
            mem_ready_out !== 1'b1 || alu_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got v=%0b s=%0b o=%0b d=%0d val=%h ready=%0b stall=%0b want zeros ready=1",
                     cdb_valid_out, cdb_src_out, alu_overflow_out, cdb_dependency_out, cdb_value_out,
                     mem_ready_out, alu_stall_out);
        end
        idle_inputs();
        tick();
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cdb_valid_out !== 1'b0 || dut.alu_count !== 3'd0) begin
                errors++;
                $display("FAIL arst_lost[%0d]: got v=%0b cnt=%0d want 0 0", i, cdb_valid_out, dut.alu_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_backpressure();
        test_flush();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
